// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: RAW stalls, taken-branch flushes and multi-cycle
// execute stalls, with saturating stall/flush performance counters.
module hazard_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  rs1_addr_D,
    input  logic [2:0]  rs2_addr_D,
    input  logic        rs1_used_D,
    input  logic        rs2_used_D,
    input  logic [2:0]  reg_write_addr_E,
    input  logic        reg_write_E,
    input  logic [2:0]  reg_write_addr_W,
    input  logic        reg_write_W,
    input  logic        branch_taken_E,
    input  logic        mc_start_E,
    input  logic [3:0]  mc_latency_E,
    input  logic        clear_counters,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_F,
    output logic        flush_D,
    output logic        pc_write_en,
    output logic        kill_E,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_events
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_events;

    logic        w_raw1;
    logic        w_raw2;
    logic        w_raw;
    logic        w_mc_go;
    logic        w_flush_evt;

    // r0 is a real register here, so no zero-address exclusion.
    assign w_raw1 = rs1_used_D &&
                    ((reg_write_E && (rs1_addr_D == reg_write_addr_E)) ||
                     (reg_write_W && (rs1_addr_D == reg_write_addr_W)));
    assign w_raw2 = rs2_used_D &&
                    ((reg_write_E && (rs2_addr_D == reg_write_addr_E)) ||
                     (reg_write_W && (rs2_addr_D == reg_write_addr_W)));
    assign w_raw   = w_raw1 || w_raw2;
    assign w_mc_go = mc_start_E && (mc_latency_E >= 4'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        flush_F     = 1'b0;
        flush_D     = 1'b0;
        kill_E      = 1'b0;
        pc_write_en = 1'b1;
        w_flush_evt = 1'b0;
        if (reset) begin
            pc_write_en = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (branch_taken_E) begin
                        flush_F     = 1'b1;
                        flush_D     = 1'b1;
                        w_flush_evt = 1'b1;
                    end else if (w_mc_go) begin
                        stall_F     = 1'b1;
                        stall_D     = 1'b1;
                        kill_E      = 1'b1;
                        pc_write_en = 1'b0;
                        w_cnt_nxt   = mc_latency_E - 4'd2;
                        w_state_nxt = (mc_latency_E == 4'd2) ? S_DONE : S_BUSY;
                    end else if (w_raw) begin
                        stall_F     = 1'b1;
                        flush_D     = 1'b1;
                        pc_write_en = 1'b0;
                    end
                end
                S_BUSY: begin
                    // Branch and RAW are deliberately ignored while the op drains.
                    stall_F     = 1'b1;
                    stall_D     = 1'b1;
                    kill_E      = 1'b1;
                    pc_write_en = 1'b0;
                    if (r_cnt != 4'd0)
                        w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt <= 4'd1)
                        w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    // Result is captured into E/W this cycle; a new mc_start is not accepted.
                    w_state_nxt = S_IDLE;
                    if (branch_taken_E) begin
                        flush_F     = 1'b1;
                        flush_D     = 1'b1;
                        w_flush_evt = 1'b1;
                    end else if (w_raw) begin
                        stall_F     = 1'b1;
                        flush_D     = 1'b1;
                        pc_write_en = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
            r_flush_events <= 16'd0;
        end else if (clear_counters) begin
            r_stall_cycles <= 16'd0;
            r_flush_events <= 16'd0;
        end else begin
            if (!pc_write_en && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (w_flush_evt && (r_flush_events != 16'hFFFF))
                r_flush_events <= r_flush_events + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table plus hand-built
// multi-cycle, saturation and reset sequences, checked through a scoreboard queue.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  rs1_addr_D = '0, rs2_addr_D = '0;
    logic        rs1_used_D = 1'b0, rs2_used_D = 1'b0;
    logic [2:0]  reg_write_addr_E = '0, reg_write_addr_W = '0;
    logic        reg_write_E = 1'b0, reg_write_W = 1'b0;
    logic        branch_taken_E = 1'b0, mc_start_E = 1'b0, clear_counters = 1'b0;
    logic [3:0]  mc_latency_E = '0;
    logic        stall_F, stall_D, flush_F, flush_D, pc_write_en, kill_E;
    logic [15:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    hazard_control_unit dut (
        .clk(clk), .reset(reset),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .reg_write_addr_E(reg_write_addr_E), .reg_write_E(reg_write_E),
        .reg_write_addr_W(reg_write_addr_W), .reg_write_W(reg_write_W),
        .branch_taken_E(branch_taken_E),
        .mc_start_E(mc_start_E), .mc_latency_E(mc_latency_E),
        .clear_counters(clear_counters),
        .stall_F(stall_F), .stall_D(stall_D), .flush_F(flush_F), .flush_D(flush_D),
        .pc_write_en(pc_write_en), .kill_E(kill_E),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    // Expected output vector: {stall_F, stall_D, flush_F, flush_D, pc_write_en, kill_E}
    localparam logic [5:0] NONE = 6'b000010;
    localparam logic [5:0] RAW  = 6'b100100;
    localparam logic [5:0] BR   = 6'b001110;
    localparam logic [5:0] MC   = 6'b110001;

    typedef struct {
        string      nm;
        logic [2:0] r1, r2, ea, wa;
        logic       u1, u2, e, w, br, mc, clr;
        logic [3:0] L;
        logic [5:0] exp;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_stall = 16'd0;
    logic [15:0] m_flush = 16'd0;
    logic [5:0]  sbq[$];
    vec_t        tbl[$];

    function automatic vec_t mk(input string nm,
                                input logic [2:0] r1, input logic u1,
                                input logic [2:0] r2, input logic u2,
                                input logic [2:0] ea, input logic e,
                                input logic [2:0] wa, input logic w,
                                input logic br, input logic mc, input logic [3:0] L,
                                input logic clr, input logic [5:0] exp);
        vec_t v;
        v.nm = nm; v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
        v.ea = ea; v.e = e; v.wa = wa; v.w = w;
        v.br = br; v.mc = mc; v.L = L; v.clr = clr; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t idle(input string nm);
        return mk(nm, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, NONE);
    endfunction

    function automatic vec_t mcv(input string nm, input logic [3:0] L, input logic [5:0] exp);
        return mk(nm, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, L, 1'b0, exp);
    endfunction

    function automatic vec_t rawv(input string nm, input logic br, input logic clr, input logic [5:0] exp);
        return mk(nm, 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, br, 1'b0, 4'd0, clr, exp);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rs1_addr_D = v.r1; rs1_used_D = v.u1; rs2_addr_D = v.r2; rs2_used_D = v.u2;
        reg_write_addr_E = v.ea; reg_write_E = v.e;
        reg_write_addr_W = v.wa; reg_write_W = v.w;
        branch_taken_E = v.br; mc_start_E = v.mc; mc_latency_E = v.L;
        clear_counters = v.clr;
    endtask

    // One clock cycle: drive after the edge, compare mid-cycle, then advance the counter model.
    task automatic cyc(input vec_t v);
        logic [5:0] e;
        @(posedge clk);
        #1;
        drive(v);
        sbq.push_back(v.exp);
        @(negedge clk);
        e = sbq.pop_front();
        chk({v.nm, ".outs"}, {10'd0, stall_F, stall_D, flush_F, flush_D, pc_write_en, kill_E}, {10'd0, e});
        chk({v.nm, ".stall_cycles"}, stall_cycles, m_stall);
        chk({v.nm, ".flush_events"}, flush_events, m_flush);
        if (v.clr) begin
            m_stall = 16'd0;
            m_flush = 16'd0;
        end else begin
            if (!e[1] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (e[3] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) begin
            @(negedge clk);
            chk("reset.outs", {10'd0, stall_F, stall_D, flush_F, flush_D, pc_write_en, kill_E}, 16'd0);
            chk("reset.stall_cycles", stall_cycles, 16'd0);
            chk("reset.flush_events", flush_events, 16'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        tbl.push_back(idle("idle0"));
        tbl.push_back(rawv("raw_e", 1'b0, 1'b0, RAW));
        tbl.push_back(mk("raw_w", 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, RAW));
        tbl.push_back(mk("raw_clear", 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, NONE));
        tbl.push_back(mk("raw_rs2_w", 3'd1, 1'b0, 3'd5, 1'b1, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, RAW));
        tbl.push_back(mk("unused_src", 3'd4, 1'b0, 3'd4, 1'b0, 3'd4, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, NONE));
        tbl.push_back(mk("raw_r0", 3'd0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, RAW));
        tbl.push_back(mk("addr_miss", 3'd6, 1'b1, 3'd7, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, NONE));
        tbl.push_back(mk("we_off", 3'd6, 1'b1, 3'd7, 1'b1, 3'd6, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, NONE));
        tbl.push_back(rawv("br_raw", 1'b1, 1'b0, BR));
        tbl.push_back(mk("br_only", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, BR));
        tbl.push_back(mcv("mc_L1", 4'd1, NONE));
        tbl.push_back(mcv("mc_L0", 4'd0, NONE));
        tbl.push_back(mk("mc_L0_raw", 3'd3, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, RAW));
        tbl.push_back(mk("br_over_mc", 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, BR));
        tbl.push_back(mcv("mc_L2_c1", 4'd2, MC));
        tbl.push_back(mcv("mc_L2_done", 4'd2, NONE));
        tbl.push_back(idle("mc_L2_idle"));
        foreach (tbl[i]) cyc(tbl[i]);

        // L=4 held: three stall cycles, DONE on the fourth
        for (int i = 0; i < 3; i++) cyc(mcv("mc_L4_stall", 4'd4, MC));
        cyc(mcv("mc_L4_done", 4'd4, NONE));
        cyc(idle("mc_L4_idle"));

        for (int i = 0; i < 2; i++) cyc(mcv("mc_L3_stall", 4'd3, MC));
        cyc(mcv("mc_L3_done", 4'd3, NONE));

        for (int i = 0; i < 14; i++) cyc(mcv("mc_L15_stall", 4'd15, MC));
        cyc(mcv("mc_L15_done", 4'd15, NONE));
        cyc(idle("mc_L15_idle"));

        // Branch and RAW ignored in BUSY
        cyc(mcv("busy_br_c1", 4'd4, MC));
        cyc(rawv("busy_br_c2", 1'b1, 1'b0, MC));
        cyc(rawv("busy_br_c3", 1'b1, 1'b0, MC));
        cyc(idle("busy_br_done"));

        // Branch, then RAW, resolved in DONE
        cyc(mcv("done_br_c1", 4'd2, MC));
        cyc(rawv("done_br", 1'b1, 1'b0, BR));
        cyc(idle("done_br_idle"));
        cyc(mcv("done_raw_c1", 4'd2, MC));
        cyc(rawv("done_raw", 1'b0, 1'b0, RAW));
        cyc(idle("done_raw_idle"));

        // Saturation, then clear coincident with a stall
        for (int i = 0; i < 65540; i++) cyc(rawv("sat_stall", 1'b0, 1'b0, RAW));
        cyc(idle("sat_hold"));
        chk("sat_value", stall_cycles, 16'hFFFF);
        cyc(rawv("clr_on_stall", 1'b0, 1'b1, RAW));
        cyc(idle("after_clr"));
        chk("clr_value", stall_cycles, 16'd0);

        // Reset in the middle of an L=8 op
        cyc(mcv("rst_busy_c1", 4'd8, MC));
        cyc(mcv("rst_busy_c2", 4'd8, MC));
        @(posedge clk);
        #1 drive(mcv("rst_busy_c3", 4'd8, MC));
        chk("rst_busy_c3_pre", {10'd0, stall_F, stall_D, flush_F, flush_D, pc_write_en, kill_E}, {10'd0, MC});
        #1 reset = 1'b1;
        #1;
        chk("rst_async.outs", {10'd0, stall_F, stall_D, flush_F, flush_D, pc_write_en, kill_E}, 16'd0);
        chk("rst_async.stall_cycles", stall_cycles, 16'd0);
        chk("rst_async.flush_events", flush_events, 16'd0);
        m_stall = 16'd0;
        m_flush = 16'd0;
        @(posedge clk);
        #1;
        drive(idle("rst_rel"));
        reset = 1'b0;
        cyc(idle("post_rst_idle"));
        cyc(idle("post_rst_idle2"));
        cyc(mcv("post_rst_L2", 4'd2, MC));
        cyc(idle("post_rst_done"));
        cyc(idle("post_rst_end"));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: rs1_addr_D, rs2_addr_D  in  3 each  decode-stage source registers.
REQ-004 SHALL have: rs1_used_D, rs2_used_D  in  1 each  source actually read.
REQ-005 SHALL have: reg_write_addr_E  in  3, reg_write_E  in  1  execute-stage destination and write enable.
REQ-006 SHALL have: reg_write_addr_W  in  3, reg_write_W  in  1  writeback-stage destination and write enable.
REQ-007 SHALL have: branch_taken_E  in  1  taken branch/jump resolved in execute.
REQ-008 SHALL have: mc_start_E  in  1, mc_latency_E  in  4  multi-cycle op in execute and its total cycles L.
REQ-009 SHALL have: clear_counters  in  1  synchronous counter clear.
REQ-010 SHALL have outputs: stall_F, stall_D, flush_F, flush_D  1 each  drive the F/D and D/E pipeline-register controls.
REQ-011 SHALL have outputs: pc_write_en  1 (PC update enable), kill_E  1 (masks reg_write/mem_write entering E/W).
REQ-012 SHALL have outputs: stall_cycles  16, flush_events  16  saturating performance counters.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, BUSY, DONE, with 4-bit down-counter cnt.
REQ-014 Outputs SHALL be combinational from state, cnt, and inputs; default: all stall/flush/kill 0, pc_write_en 1.
REQ-015 Priority in IDLE and DONE SHALL be: branch flush > multi-cycle start (IDLE only) > RAW stall.
REQ-016 Branch: branch_taken_E=1 SHALL assert flush_F=1 and flush_D=1 with pc_write_en=1 for that cycle; the state is unchanged.
REQ-017 RAW hazard SHALL be (rsN_used_D and reg_write_E and rsN_addr_D==reg_write_addr_E) or (rsN_used_D and reg_write_W and rsN_addr_D==reg_write_addr_W), N=1,2; register r0 is not excluded.
REQ-018 RAW hazard SHALL assert stall_F=1, flush_D=1, pc_write_en=0 (one bubble per cycle until clear).
REQ-019 In IDLE, mc_start_E=1 with L>=2 SHALL assert stall_F=1, stall_D=1, kill_E=1, pc_write_en=0; cnt<=L-2; next state DONE if L==2, else BUSY.
REQ-020 mc_start_E with L of 0 or 1 SHALL be treated as a single-cycle op (no stall, no transition).
REQ-021 BUSY SHALL assert stall_F, stall_D, kill_E =1 and pc_write_en=0; ignore branch_taken_E and RAW; cnt<=cnt-1; go to DONE when cnt==1.
REQ-022 DONE SHALL deassert all multi-cycle stalls so E/W captures the result; mc_start_E is ignored; branch and RAW are evaluated; next state is IDLE.
REQ-023 Total stall cycles for a multi-cycle op SHALL be exactly L-1; the result SHALL be captured on cycle L.
REQ-024 stall_cycles SHALL increment on every cycle with pc_write_en==0 and reset deasserted, saturating at 16'hFFFF.
REQ-025 flush_events SHALL increment once per cycle in which branch_taken_E causes a flush, saturating at 16'hFFFF.
REQ-026 clear_counters=1 SHALL zero both counters on the next edge, overriding increment.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, cnt 0, and both counters 0, regardless of the clock.
REQ-028 While reset=1, stall_F, stall_D, flush_F, flush_D, and kill_E SHALL be 0 and pc_write_en SHALL be 0.
REQ-029 Reset asserted in BUSY SHALL abandon the op; after release, the FSM restarts in IDLE with no residual stall.

Verification
REQ-030 RAW: rs1_addr_D=3, rs1_used_D=1, reg_write_E=1, reg_write_addr_E=3 -> stall_F=1, flush_D=1, pc_write_en=0; after E moves on with W dest=3 -> stall again; next cycle clear -> pc_write_en=1; stall_cycles=2.
REQ-031 Multi-cycle: mc_start_E=1, L=4 held -> stall_F/stall_D/kill_E high for exactly 3 cycles (IDLE, BUSY, BUSY); DONE on cycle 4 with all low; then IDLE.
REQ-032 Boundary L: L=2 -> 1 stall cycle then DONE; L=1 and L=0 -> no stall; L=15 -> 14 stall cycles.
REQ-033 Simultaneous: branch_taken_E=1 with a RAW hazard -> flush_F=flush_D=1, pc_write_en=1, no stall; branch_taken_E=1 during BUSY -> ignored, flush_events unchanged.
REQ-034 Saturation/clear: preload via 65536+ stalled cycles -> stall_cycles stays 16'hFFFF; clear_counters coincident with a stall -> 0.
REQ-035 Reset mid-BUSY (L=8, cycle 3) -> outputs drop immediately with pc_write_en=0; after release -> IDLE, counters 0, stalls 0.
